crosp_dbgmon: RTL
=================

# crosp_dbgmon

Parametrised debug and performance monitor for a CROSP core. It generalises the fixed two-lane PC/IR debug latches and the 12-event delta bus into N commit lanes and M saturating event counters. It adds a buffered commit trace stream with a ready/valid handshake and loss accounting. It sits beside the core wrapper and observes only commit and event outputs; it never back-pressures the core.

## Interface
Parameters:
- `cwd`, 2, commit lanes observed per cycle
- `nevt`, 12, number of event channels
- `evw`, 4, width of each per-cycle event delta
- `cntw`, 48, event counter width
- `tqsz`, 16, trace FIFO depth in records, power of two, ≥ cwd
- `dropw`, 16, drop counter width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous assert, active low
- `com_valid`  in  cwd  lane i committed this cycle
- `com_pc`  in  cwd×64  committed PC per lane
- `com_ir`  in  cwd×32  committed instruction per lane
- `evt_delta`  in  nevt×evw  per-cycle event increments, same encoding as the core's pmd bus
- `ospid`  in  32  current OS PID from the HINT tracker
- `pid_match`  in  32  PID filter value, used only with the filter macro
- `trc_en`  in  1  trace enable level
- `cnt_clr`  in  1  synchronous clear of all event counters
- `cnt_sel`  in  clog2(nevt)  counter read select
- `cnt_rdat`  out  cntw  selected counter value, registered
- `last_pcir`  out  cwd×64  {pc[31:0], ir} of the last valid commit per lane
- `tr_valid`  out  1  trace record available
- `tr_ready`  in  1  sink accepts record
- `tr_data`  out  64  {pc[31:0], ir}
- `tr_drop`  out  dropw  records lost, saturating
- `tr_idle`  out  1  trace FSM in OFF

## Operation
- Reset values: all outputs 0 except `tr_idle`=1. All counters and the FIFO are cleared. The FSM is in OFF.
- Event counters:
  - Each cycle, `cnt[k] += evt_delta[k]`, zero-extended.
  - A counter saturates at 2^cntw−1 and never wraps.
  - `cnt_clr` zeros all counters. The delta from that same cycle is discarded.
- `last_pcir[i]` updates whenever `com_valid[i]`, independent of trace state.
- Trace FSM:
  - OFF → RUN when `trc_en`=1.
  - RUN → FLUSH when `trc_en`=0.
  - FLUSH → RUN when `trc_en`=1.
  - FLUSH → OFF when the FIFO is empty and `trc_en`=0.
  - Enqueue happens only in RUN.
- Enqueue:
  - Valid lanes are packed in ascending lane order.
  - Free space is `tqsz − count`, sampled before this cycle's pop; a same-cycle pop does not create room.
  - The first `min(valid, free)` records are written. The remainder are dropped and `tr_drop` is incremented by the dropped count, saturating.
- Dequeue: a pop occurs when `tr_valid & tr_ready`. `tr_data` is the FIFO head, held stable while `tr_valid & !tr_ready`.
- `tr_drop` is cleared only by reset.

## Timing
- Enqueued records appear at `tr_valid` one cycle later, at the earliest.
- `cnt_rdat` shows the counter value at the selected index one cycle after `cnt_sel`. That value includes updates up to the previous cycle.
- `tr_idle` is registered and reflects the FSM state.
- Reset asserted mid-stream drops FIFO contents immediately and asynchronously.
- Full FIFO with `tr_ready`=1 and `cwd` commits: exactly one record is popped and all `cwd` records are dropped (free space is 0 pre-pop).
- Pointers wrap modulo `tqsz`. A separate count of width clog2(tqsz)+1 distinguishes full from empty.

## Configuration
- `DBGMON_PIDFILTER_EN` defined: in RUN, a lane is eligible for trace only if `ospid == pid_match`. Ineligible lanes are neither enqueued nor counted as drops.
- Macro undefined: `pid_match` is ignored and all valid lanes are eligible.

## Structure
- The shared `types` package holds `trc_rec_t` (pc[31:0], ir[31:0]) and the `dbgmon_state_t` enum (OFF, RUN, FLUSH).
- Sub-module `trc_fifo`: `cwd`-push / 1-pop FIFO of `trc_rec_t` with a registered count and a `free` output. Counters, packing, FSM and drop logic stay in the top module.

## Test plan
- Reset, then `evt_delta[1]`=1 for 100 cycles, `cnt_sel`=1 → `cnt_rdat`=100 one cycle after the last increment has registered. `cnt_clr` pulse → next read is 0.
- Preload a counter near saturation at `cntw`=8 with delta 15 → value stays 255.
- `trc_en`=1, 2 commits per cycle, `tr_ready`=0, `tqsz`=16 → 8 cycles fill the FIFO. The next 3 cycles give `tr_drop`=6. Then, with `tr_ready`=1, the records drain in lane order with the correct PC/IR.
- Lane 1 valid only, PC 0x80000004, IR 0x00000013 → `tr_data`=0x8000000400000013 and `last_pcir[1]` is the same value. `last_pcir[0]` is unchanged.
- With 5 records queued, deassert `trc_en` → FSM enters FLUSH and new commits are ignored. After 5 pops, `tr_idle`=1.
- With `DBGMON_PIDFILTER_EN`, `pid_match`=7: commits with `ospid`=3 produce no records and no drops; with `ospid`=7 they are enqueued.

Source files
------------

// File: rtl/crosp_dbgmon_pkg.sv
// Shared types for the CROSP debug/performance monitor: trace record layout and trace FSM states.
package crosp_dbgmon_pkg;

    // Packed so that a record reads as {pc[31:0], ir} on the trace bus.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } trc_rec_t;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } dbgmon_state_t;

endpackage

// File: rtl/crosp_dbgmon_trc_fifo.sv
// Trace record FIFO: up to cwd pushes and one pop per cycle, registered count, free-space output.
module trc_fifo
    import crosp_dbgmon_pkg::*;
#(
    parameter int cwd  = 2,
    parameter int tqsz = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [$clog2(tqsz):0]  push_cnt,
    input  trc_rec_t [cwd-1:0]     push_data,
    input  logic                   pop,
    output trc_rec_t               head,
    output logic [$clog2(tqsz):0]  count,
    output logic [$clog2(tqsz):0]  free
);

    localparam int AW = $clog2(tqsz);
    localparam int CW = AW + 1;

    trc_rec_t      mem_q [tqsz];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // The caller never pushes more than free nor pops an empty FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q + push_cnt[AW-1:0];
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + push_cnt - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the record store is not reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int j = 0; j < cwd; j++) begin
            if (CW'(j) < push_cnt) begin
                mem_q[wr_ptr_q + AW'(j)] <= push_data[j];
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign free  = CW'(tqsz) - count_q;

endmodule

// File: rtl/crosp_dbgmon.sv
// CROSP debug monitor: per-lane last PC/IR, saturating event counters, buffered commit trace.
// Optional feature macro DBGMON_PIDFILTER_EN restricts trace to commits where ospid == pid_match.
module crosp_dbgmon
    import crosp_dbgmon_pkg::*;
#(
    parameter int cwd   = 2,
    parameter int nevt  = 12,
    parameter int evw   = 4,
    parameter int cntw  = 48,
    parameter int tqsz  = 16,
    parameter int dropw = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [cwd-1:0]                           com_valid,
    input  logic [cwd-1:0][63:0]                     com_pc,
    input  logic [cwd-1:0][31:0]                     com_ir,
    input  logic [nevt-1:0][evw-1:0]                 evt_delta,
    input  logic [31:0]                              ospid,
    input  logic [31:0]                              pid_match,
    input  logic                                     trc_en,
    input  logic                                     cnt_clr,
    input  logic [(nevt > 1 ? $clog2(nevt) : 1)-1:0] cnt_sel,
    output logic [cntw-1:0]                          cnt_rdat,
    output logic [cwd-1:0][63:0]                     last_pcir,
    output logic                                     tr_valid,
    input  logic                                     tr_ready,
    output logic [63:0]                              tr_data,
    output logic [dropw-1:0]                         tr_drop,
    output logic                                     tr_idle
);

    localparam int CW = $clog2(tqsz) + 1;
    localparam int LW = $clog2(cwd + 1);
    localparam int IW = (cwd > 1) ? $clog2(cwd) : 1;

    dbgmon_state_t              state_q;
    logic                       tr_idle_q;
    logic [nevt-1:0][cntw-1:0]  cnt_q, cnt_d;
    logic [cntw-1:0]            cnt_rdat_q, cnt_rdat_d;
    logic [cwd-1:0][63:0]       last_pcir_q, last_pcir_d;
    logic [dropw-1:0]           drop_q, drop_d;
    logic [cntw:0]              cnt_sum;
    logic [dropw:0]             drop_sum;
    logic                       pid_ok;
    trc_rec_t [cwd-1:0]         pk;
    logic [LW-1:0]              nv;
    logic [CW-1:0]              nv_ext, n_push, n_drop;
    logic [CW-1:0]              fifo_count, fifo_free;
    trc_rec_t                   fifo_head;
    logic                       pop;

`ifdef DBGMON_PIDFILTER_EN
    assign pid_ok = (ospid == pid_match);
`else
    logic unused_pid;
    assign unused_pid = ^{ospid, pid_match};
    assign pid_ok     = 1'b1;
`endif

    // NOTE: every always_comb output is given a default first, so no latch can be inferred.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_sum = '0;
        for (int k = 0; k < nevt; k++) begin
            cnt_sum  = {1'b0, cnt_q[k]} + (cntw + 1)'(evt_delta[k]);
            cnt_d[k] = cnt_sum[cntw] ? {cntw{1'b1}} : cnt_sum[cntw-1:0];
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end
        cnt_rdat_d = (int'(cnt_sel) < nevt) ? cnt_q[cnt_sel] : '0;

        last_pcir_d = last_pcir_q;
        for (int i = 0; i < cwd; i++) begin
            if (com_valid[i]) begin
                last_pcir_d[i] = {com_pc[i][31:0], com_ir[i]};
            end
        end
    end

    // Pack eligible lanes low-first, then split into what fits (pre-pop space) and what is lost.
    always_comb begin
        pk = '0;
        nv = '0;
        for (int i = 0; i < cwd; i++) begin
            if (com_valid[i] && state_q == RUN && pid_ok) begin
                pk[nv[IW-1:0]] = '{pc: com_pc[i][31:0], ir: com_ir[i]};
                nv             = nv + LW'(1);
            end
        end
        nv_ext   = CW'(nv);
        n_push   = (nv_ext > fifo_free) ? fifo_free : nv_ext;
        n_drop   = nv_ext - n_push;
        drop_sum = {1'b0, drop_q} + (dropw + 1)'(n_drop);
        drop_d   = drop_sum[dropw] ? {dropw{1'b1}} : drop_sum[dropw-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cnt_rdat_q  <= '0;
            last_pcir_q <= '0;
            drop_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cnt_rdat_q  <= cnt_rdat_d;
            last_pcir_q <= last_pcir_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OFF;
            tr_idle_q <= 1'b1;
        end else begin
            case (state_q)
                OFF: begin
                    if (trc_en) begin
                        state_q   <= RUN;
                        tr_idle_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (!trc_en) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (trc_en) begin
                        state_q <= RUN;
                    end else if (fifo_count == '0) begin
                        state_q   <= OFF;
                        tr_idle_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= OFF;
                    tr_idle_q <= 1'b1;
                end
            endcase
        end
    end

    trc_fifo #(
        .cwd  (cwd),
        .tqsz (tqsz)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_cnt  (n_push),
        .push_data (pk),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .free      (fifo_free)
    );

    assign tr_valid  = (fifo_count != '0);
    assign pop       = tr_valid & tr_ready;
    assign tr_data   = tr_valid ? {fifo_head.pc, fifo_head.ir} : 64'd0;
    assign tr_drop   = drop_q;
    assign tr_idle   = tr_idle_q;
    assign cnt_rdat  = cnt_rdat_q;
    assign last_pcir = last_pcir_q;

endmodule
